lcd_ctrl: RTL and testbench

- Consumer end of the memory-mapped LCD register that the LSU writes.
- Takes a command word, detects a new request through a toggle handshake, and drives the HD44780 8-bit parallel interface.
- Generates the setup, enable-pulse, hold and execution-wait timing, so firmware never bit-bangs EN.
- Returns busy and acknowledge status for the LSU read path.

---
 rtl/lcd_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller fed by a toggle-handshake command register.
// Optional macro LCD_INIT_EN adds an autonomous power-up initialisation sequence.
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_cmd,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    localparam int T_MAX = (T_EXEC > T_CLEAR) ? T_EXEC : T_CLEAR;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_PWRUP = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          ack_r, ack_s, tog_r, tog_s, long_r, long_s;
    logic          rs_r, rs_s, en_r, en_s, busy_r, busy_s, on_r;
    logic [7:0]    data_r, data_s;
    logic          cnt_zero_s, pending_s, is_clear_s;
    logic          init_act_s, init_more_s, load_init_s;
    logic [7:0]    init_data_s;
    logic          unused_cmd_s;

    assign unused_cmd_s = ^{i_lcd_cmd[30:17], i_lcd_cmd[15:10], i_lcd_cmd[8]};
    assign cnt_zero_s   = (cnt_r == {CW{1'b0}});
    assign pending_s    = (i_lcd_cmd[16] != ack_r);
    assign is_clear_s   = !rs_r && (data_r[7:2] == 6'd0) && (data_r[1:0] != 2'd0);

`ifdef LCD_INIT_EN
    logic       init_act_r, init_act_nxt_s;
    logic [2:0] init_idx_r, init_idx_nxt_s;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            3'd5:             init_byte = 8'h06;
            default:          init_byte = 8'h00;
        endcase
    endfunction

    assign init_act_s  = init_act_r;
    assign init_more_s = init_act_r && (init_idx_r != 3'd5);
    assign load_init_s = (state_r == S_PWRUP && cnt_zero_s) ||
                         (state_r == S_WAIT && cnt_zero_s && init_more_s);
    assign init_data_s = init_byte(init_idx_nxt_s);

    // Init sequencer: step through the command table, drop out after the last entry
    always_comb begin
        init_idx_nxt_s = init_idx_r;
        init_act_nxt_s = init_act_r;
        if (state_r == S_WAIT && cnt_zero_s && init_act_r) begin
            if (init_more_s) begin
                init_idx_nxt_s = init_idx_r + 3'd1;
            end else begin
                init_act_nxt_s = 1'b0;
            end
        end else begin
            init_idx_nxt_s = init_idx_r;
        end
    end

    // Init sequencer registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            init_act_r <= 1'b1;
            init_idx_r <= 3'd0;
        end else begin
            init_act_r <= init_act_nxt_s;
            init_idx_r <= init_idx_nxt_s;
        end
    end
`else
    assign init_act_s  = 1'b0;
    assign init_more_s = 1'b0;
    assign load_init_s = 1'b0;
    assign init_data_s = 8'h00;
`endif

    // State register and all registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
`ifdef LCD_INIT_EN
            state_r <= S_PWRUP;
            cnt_r   <= CW'(T_CLEAR - 1);
            busy_r  <= 1'b1;
`else
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
`endif
            ack_r   <= 1'b0;
            tog_r   <= 1'b0;
            long_r  <= 1'b0;
            rs_r    <= 1'b0;
            data_r  <= 8'h00;
            en_r    <= 1'b0;
            on_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            ack_r   <= ack_s;
            tog_r   <= tog_s;
            long_r  <= long_s;
            rs_r    <= rs_s;
            data_r  <= data_s;
            en_r    <= en_s;
            on_r    <= i_lcd_cmd[31];
        end
    end

    // Next-state logic: each timed phase ends when the counter reaches zero
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (pending_s)  state_s = S_SETUP; else state_s = S_IDLE;
            S_SETUP: if (cnt_zero_s) state_s = S_PULSE; else state_s = S_SETUP;
            S_PULSE: if (cnt_zero_s) state_s = S_HOLD;  else state_s = S_PULSE;
            S_HOLD:  if (cnt_zero_s) state_s = S_WAIT;  else state_s = S_HOLD;
            S_WAIT: begin
                if (cnt_zero_s) state_s = init_more_s ? S_SETUP : S_IDLE;
                else            state_s = S_WAIT;
            end
            S_PWRUP: if (cnt_zero_s) state_s = S_SETUP; else state_s = S_PWRUP;
            default: state_s = S_IDLE;
        endcase
    end

    // Output/datapath logic: counter reload on entry, command latch, handshake
    always_comb begin
        cnt_s = cnt_r;
        if (state_s != state_r) begin
            case (state_s)
                S_SETUP: cnt_s = CW'(T_SETUP - 1);
                S_PULSE: cnt_s = CW'(T_PULSE - 1);
                S_HOLD:  cnt_s = CW'(T_HOLD - 1);
                S_WAIT:  cnt_s = long_r ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
                default: cnt_s = {CW{1'b0}};
            endcase
        end else if (!cnt_zero_s) begin
            cnt_s = cnt_r - CW'(1);
        end else begin
            cnt_s = cnt_r;
        end

        rs_s   = rs_r;
        data_s = data_r;
        tog_s  = tog_r;
        if (state_r == S_IDLE && pending_s) begin
            rs_s   = i_lcd_cmd[9];
            data_s = i_lcd_cmd[7:0];
            tog_s  = i_lcd_cmd[16];
        end else if (load_init_s) begin
            rs_s   = 1'b0;
            data_s = init_data_s;
        end else begin
            rs_s   = rs_r;
        end

        // Wait length is fixed once the pulse starts, from the latched command
        if (state_r == S_SETUP && state_s == S_PULSE) long_s = is_clear_s;
        else                                          long_s = long_r;

        if (state_r == S_WAIT && cnt_zero_s && !init_act_s) ack_s = tog_r;
        else                                                ack_s = ack_r;

        en_s   = (state_s == S_PULSE);
        busy_s = (state_s != S_IDLE);
    end

    assign o_status   = {busy_r, 14'd0, ack_r, 16'd0};
    assign o_lcd_on   = on_r;
    assign o_lcd_en   = en_r;
    assign o_lcd_rs   = rs_r;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed handshake cases plus randomized
// transactions checked cycle by cycle against a timing-arithmetic reference model.
module tb_lcd_ctrl;

    localparam int TS = 2;
    localparam int TP = 4;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TC = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd;
    logic [31:0] status;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    int   tests = 0;
    int   fails = 0;
    logic tog_m = 1'b0;

    lcd_ctrl #(
        .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_CLEAR(TC)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_lcd_cmd(cmd), .o_status(status),
        .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Clear/home commands are instruction bytes 0x01..0x03
    function automatic int wait_len(input logic r, input logic [7:0] d);
        if (r == 1'b0 && d >= 8'd1 && d <= 8'd3) return TC;
        return TE;
    endfunction

    task automatic request(input logic r, input logic [7:0] d);
        tog_m     = ~tog_m;
        cmd[16]   = tog_m;
        cmd[9]    = r;
        cmd[7:0]  = d;
    endtask

    // kind 0: none, 1: new request inj_d mid-flight, 2: double toggle, 3: scramble low bits
    task automatic run_txn(input logic r, input logic [7:0] d, input int inj_j,
                           input int kind, input logic [7:0] inj_d);
        int   dur;
        logic tog_start;
        dur       = TS + TP + TH + wait_len(r, d);
        tog_start = tog_m;
        for (int j = 1; j <= dur; j++) begin
            tick;
            chk("busy", status[31], 1'b1);
            chk("en", lcd_en, (j > TS) && (j <= TS + TP));
            chk("rs", lcd_rs, r);
            chk("data", lcd_data, d);
            chk("rw", lcd_rw, 1'b0);
            if (kind == 1 && j == inj_j) begin
                request(1'b1, inj_d);
            end
            if (kind == 2 && (j == inj_j || j == inj_j + 2)) begin
                tog_m   = ~tog_m;
                cmd[16] = tog_m;
            end
            if (kind == 3 && j == inj_j) begin
                cmd[15:0] = 16'($urandom);
            end
        end
        tick;
        chk("busy_fall", status[31], 1'b0);
        chk("en_idle", lcd_en, 1'b0);
        chk("status", status, {1'b0, 14'd0, tog_start, 16'd0});
        chk("on", lcd_on, cmd[31]);
    endtask

    initial begin
        logic       r;
        logic [7:0] d;
        int         gap;
        int         en_seen;

        reset = 1'b0;
        cmd   = 32'h0000_0000;
        tick;
        tick;
        chk("rst_status", status, 32'h0000_0000);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_on", lcd_on, 1'b0);
        reset = 1'b1;
        tick;
        chk("idle_status", status, 32'h0000_0000);

        // Data write 'A'
        cmd = 32'h0001_0241;
        tog_m = 1'b1;
        run_txn(1'b1, 8'h41, 0, 0, 8'h00);

        // Clear uses the long wait, display-on the short one
        request(1'b0, 8'h01);
        run_txn(1'b0, 8'h01, 0, 0, 8'h00);
        request(1'b0, 8'h0C);
        run_txn(1'b0, 8'h0C, 0, 0, 8'h00);

        // Second request mid-pulse waits for the first to finish
        request(1'b1, 8'h41);
        run_txn(1'b1, 8'h41, 4, 1, 8'h42);
        run_txn(1'b1, 8'h42, 0, 0, 8'h00);
        tick;

        // Double toggle while busy cancels out
        request(1'b1, 8'h33);
        run_txn(1'b1, 8'h33, 4, 2, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("no_second", status[31], 1'b0);
        end

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick;
            r   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 4));
            else                           d = 8'($urandom);
            cmd = $urandom;
            cmd[16] = tog_m;
            request(r, d);
            run_txn(r, d, $urandom_range(1, 15), 3 * $urandom_range(0, 1), 8'h00);
        end

        // Reset in the middle of WAIT
        request(1'b0, 8'h0C);
        repeat (12) tick;
        chk("pre_rst_busy", status[31], 1'b1);
        reset = 1'b0;
        cmd   = 32'h0000_0000;
        tog_m = 1'b0;
        tick;
        chk("mid_rst_en", lcd_en, 1'b0);
        chk("mid_rst_data", lcd_data, 8'h00);
        chk("mid_rst_status", status, 32'h0000_0000);
        reset = 1'b1;
        en_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (lcd_en) en_seen++;
        end
        chk("post_rst_no_en", en_seen, 0);
        chk("post_rst_busy", status[31], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
